// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings and helpers for the memory-stage load/store unit.
// Opcodes, func3 size codes, FSM state type and access legality checks.
package mem_stage_lsu_pkg;

    localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;

    function automatic logic legal_f3(input logic is_store, input logic [2:0] func3);
        if (is_store)
            return func3 inside {F3_B, F3_H, F3_W};
        else
            return func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    // func3[1:0] carries the access size for every legal encoding
    function automatic logic misaligned(input logic [2:0] func3, input logic [1:0] addr_lo);
        case (func3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port: req/ready request handshake plus rvalid load return.
interface mem_stage_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Load alignment: picks the addressed byte/half lane from the returned word
// and sign- or zero-extends it according to func3.
module mem_stage_lsu_load_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  func3,
    output logic [31:0] value
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        value = rdata;
        case (func3)
            F3_B:    value = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    value = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   value = {24'h000000, shifted[7:0]};
            F3_HU:   value = {16'h0000, shifted[15:0]};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory stage of the 5-stage core: issues loads/stores on the data-memory port,
// stalls the pipeline while an access is outstanding and drives the MEM/WB register.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ex_valid,
    input  logic [6:0]             ex_opcode,
    input  logic [2:0]             ex_func3,
    input  logic [31:0]            ex_result_alu,
    input  logic [31:0]            ex_store_data,
    input  logic [4:0]             ex_wb_rd,
    input  logic                   ex_wb_reg_file,
    mem_stage_lsu_if.master        dmem,
    output logic                   mem_stall,
    output logic                   mem_exc,
    output logic [31:0]            data_forward_mem,
    output logic                   wb_valid,
    output logic [4:0]             wb_rd,
    output logic                   wb_reg_file,
    output logic [31:0]            wb_data
);

    lsu_state_t  state, state_next;
    logic        is_load, is_store, mem_op, bad_op, legal_op;
    logic        req, we, completion;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] load_value;

    assign is_load  = ex_valid && (ex_opcode == OPCODE_LOAD);
    assign is_store = ex_valid && (ex_opcode == OPCODE_STORE);
    assign mem_op   = is_load || is_store;
    assign bad_op   = mem_op && (!legal_f3(is_store, ex_func3) ||
                                 misaligned(ex_func3, ex_result_alu[1:0]));
    assign legal_op = mem_op && !bad_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (legal_op) begin
                    if (!dmem.ready)
                        state_next = REQ;
                    else if (is_load)
                        state_next = WAIT;
                end
            end
            REQ: begin
                if (dmem.ready)
                    state_next = is_load ? WAIT : IDLE;
            end
            WAIT: begin
                if (dmem.rvalid)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ex_* is held by the upstream stall, so request fields stay stable in REQ
    always_comb begin
        req   = 1'b0;
        we    = 1'b0;
        wstrb = 4'b0000;
        wdata = ex_store_data;
        case (state)
            IDLE:    req = legal_op;
            REQ:     req = 1'b1;
            default: req = 1'b0;
        endcase
        case (ex_func3)
            F3_B:    wdata = {4{ex_store_data[7:0]}};
            F3_H:    wdata = {2{ex_store_data[15:0]}};
            default: wdata = ex_store_data;
        endcase
        if (req && is_store) begin
            we = 1'b1;
            case (ex_func3)
                F3_B:    wstrb = 4'b0001 << ex_result_alu[1:0];
                F3_H:    wstrb = 4'b0011 << ex_result_alu[1:0];
                default: wstrb = 4'b1111;
            endcase
        end
    end

    assign dmem.req   = req;
    assign dmem.we    = we;
    assign dmem.addr  = {ex_result_alu[31:2], 2'b00};
    assign dmem.wdata = wdata;
    assign dmem.wstrb = wstrb;

    assign completion       = (is_store && req && dmem.ready) || (state == WAIT && dmem.rvalid);
    assign mem_stall        = legal_op && !completion;
    assign mem_exc          = bad_op && (state == IDLE);
    assign data_forward_mem = ex_result_alu;

    mem_stage_lsu_load_align u_load_align (
        .rdata   (dmem.rdata),
        .addr_lo (ex_result_alu[1:0]),
        .func3   (ex_func3),
        .value   (load_value)
    );

    // Memory ops bubble the WB register until they complete; faulting ops never write rd
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_rd       <= 5'd0;
            wb_reg_file <= 1'b0;
            wb_data     <= 32'd0;
        end else if (legal_op) begin
            if (completion) begin
                wb_valid    <= 1'b1;
                wb_rd       <= ex_wb_rd;
                wb_reg_file <= is_load && ex_wb_reg_file && (ex_wb_rd != 5'd0);
                wb_data     <= is_load ? load_value : ex_result_alu;
            end else begin
                wb_valid    <= 1'b0;
                wb_reg_file <= 1'b0;
            end
        end else begin
            wb_valid    <= ex_valid;
            wb_rd       <= ex_wb_rd;
            wb_reg_file <= ex_valid && !bad_op && ex_wb_reg_file && (ex_wb_rd != 5'd0);
            wb_data     <= ex_result_alu;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: WB results are checked against a queue of
// expectations pushed as each instruction is issued.
module tb_mem_stage_lsu;
    import mem_stage_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_func3;
    logic [31:0] ex_result_alu;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_wb_rd;
    logic        ex_wb_reg_file;
    logic        mem_stall, mem_exc;
    logic [31:0] data_forward_mem;
    logic        wb_valid, wb_reg_file;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    mem_stage_lsu_if dmem();

    mem_stage_lsu dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_valid         (ex_valid),
        .ex_opcode        (ex_opcode),
        .ex_func3         (ex_func3),
        .ex_result_alu    (ex_result_alu),
        .ex_store_data    (ex_store_data),
        .ex_wb_rd         (ex_wb_rd),
        .ex_wb_reg_file   (ex_wb_reg_file),
        .dmem             (dmem),
        .mem_stall        (mem_stall),
        .mem_exc          (mem_exc),
        .data_forward_mem (data_forward_mem),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .wb_reg_file      (wb_reg_file),
        .wb_data          (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        rf;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t sb[$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1) begin
            n_cmp++;
            assert (sb.size() != 0)
            else begin
                n_fail++;
                $error("FAIL wb_unexpected: observed wb_valid=1 rd=%0d data=%h expected no writeback", wb_rd, wb_data);
            end
            if (sb.size() != 0) begin
                wb_exp_t e;
                e = sb.pop_front();
                chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                chk("wb_reg_file", {31'd0, wb_reg_file}, {31'd0, e.rf});
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic nop();
        ex_valid      = 1'b0;
        dmem.ready    = 1'b0;
        dmem.rvalid   = 1'b0;
        dmem.rdata    = 32'd0;
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] sdata, input logic [4:0] rd, input logic rf);
        ex_valid       = 1'b1;
        ex_opcode      = op;
        ex_func3       = f3;
        ex_result_alu  = alu;
        ex_store_data  = sdata;
        ex_wb_rd       = rd;
        ex_wb_reg_file = rf;
    endtask

    // n_wait cycles of ready=0 before acceptance, loads return k cycles after acceptance
    task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd, input int n_wait,
                          input int k, input logic [31:0] ld_word, input logic [3:0] exp_strb,
                          input logic [31:0] exp_wdata, input int exp_stall,
                          input logic [31:0] exp_wb, input logic exp_rf);
        int stalls = 0;
        logic done = 1'b0;
        wb_exp_t e;
        e.rd = rd; e.rf = exp_rf; e.data = exp_wb;
        sb.push_back(e);
        drive(st ? OPCODE_STORE : OPCODE_LOAD, f3, addr, sdata, rd, 1'b1);
        for (int c = 0; c < 40 && !done; c++) begin
            dmem.ready  = (c == n_wait);
            dmem.rvalid = !st && (c == n_wait + k);
            dmem.rdata  = dmem.rvalid ? ld_word : 32'h0;
            #1;
            if (mem_stall === 1'b1) stalls++;
            if (c <= n_wait) begin
                chk("req_active", {31'd0, dmem.req}, 32'd1);
                chk("we", {31'd0, dmem.we}, {31'd0, st});
                chk("addr", dmem.addr, {addr[31:2], 2'b00});
                chk("wstrb", {28'd0, dmem.wstrb}, {28'd0, exp_strb});
                if (st) chk("wdata", dmem.wdata, exp_wdata);
            end else begin
                chk("req_wait", {31'd0, dmem.req}, 32'd0);
            end
            chk("exc_quiet", {31'd0, mem_exc}, 32'd0);
            done = st ? (c == n_wait) : (c == n_wait + k);
            tick();
        end
        chk("access_done", {31'd0, done}, 32'd1);
        chk("stall_cycles", stalls, exp_stall);
        nop();
    endtask

    task automatic pass_through(input logic [4:0] rd, input logic rf, input logic [31:0] alu,
                                input logic exp_rf);
        wb_exp_t e;
        e.rd = rd; e.rf = exp_rf; e.data = alu;
        sb.push_back(e);
        drive(7'b0110011, 3'b000, alu, 32'h0, rd, rf);
        #1;
        chk("pt_req", {31'd0, dmem.req}, 32'd0);
        chk("pt_stall", {31'd0, mem_stall}, 32'd0);
        chk("pt_forward", data_forward_mem, alu);
        tick();
        nop();
    endtask

    task automatic faulting(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        wb_exp_t e;
        e.rd = rd; e.rf = 1'b0; e.data = addr;
        sb.push_back(e);
        drive(OPCODE_LOAD, f3, addr, 32'h0, rd, 1'b1);
        dmem.ready = 1'b1;
        #1;
        chk("exc_pulse", {31'd0, mem_exc}, 32'd1);
        chk("exc_no_req", {31'd0, dmem.req}, 32'd0);
        chk("exc_no_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        nop();
        #1;
        chk("exc_one_cycle", {31'd0, mem_exc}, 32'd0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        ex_opcode = 7'd0; ex_func3 = 3'd0; ex_result_alu = 32'd0;
        ex_store_data = 32'd0; ex_wb_rd = 5'd0; ex_wb_reg_file = 1'b0;
        nop();
        tick(); tick();
        chk("rst_req", {31'd0, dmem.req}, 32'd0);
        chk("rst_we", {31'd0, dmem.we}, 32'd0);
        chk("rst_wstrb", {28'd0, dmem.wstrb}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_exc", {31'd0, mem_exc}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_reg_file", {31'd0, wb_reg_file}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        rst_n = 1'b1;
        tick();

        // stores: SW, SB upper lane, SH upper half, then a store held off by 3 not-ready cycles
        access(1'b1, F3_W, 32'h100, 32'hDEADBEEF, 5'd5, 0, 0, 32'h0, 4'b1111, 32'hDEADBEEF, 0, 32'h100, 1'b0);
        access(1'b1, F3_B, 32'h103, 32'h000000A5, 5'd5, 0, 0, 32'h0, 4'b1000, 32'hA5A5A5A5, 0, 32'h103, 1'b0);
        access(1'b1, F3_H, 32'h102, 32'hCAFE1234, 5'd6, 0, 0, 32'h0, 4'b1100, 32'h12341234, 0, 32'h102, 1'b0);
        access(1'b1, F3_W, 32'h204, 32'h01234567, 5'd6, 3, 0, 32'h0, 4'b1111, 32'h01234567, 3, 32'h204, 1'b0);

        // loads with lane select and extension
        access(1'b0, F3_B,  32'h103, 32'h0, 5'd7, 0, 2, 32'hA5000000, 4'b0000, 32'h0, 2, 32'hFFFFFFA5, 1'b1);
        access(1'b0, F3_BU, 32'h103, 32'h0, 5'd7, 0, 2, 32'hA5000000, 4'b0000, 32'h0, 2, 32'h000000A5, 1'b1);
        access(1'b0, F3_H,  32'h102, 32'h0, 5'd8, 0, 1, 32'h80010000, 4'b0000, 32'h0, 1, 32'hFFFF8001, 1'b1);
        access(1'b0, F3_HU, 32'h102, 32'h0, 5'd8, 0, 1, 32'h80010000, 4'b0000, 32'h0, 1, 32'h00008001, 1'b1);
        access(1'b0, F3_W,  32'h104, 32'h0, 5'd9, 2, 1, 32'h12345678, 4'b0000, 32'h0, 3, 32'h12345678, 1'b1);
        access(1'b0, F3_B,  32'h101, 32'h0, 5'd0, 0, 1, 32'h00007F00, 4'b0000, 32'h0, 1, 32'h0000007F, 1'b0);

        // faulting accesses: misaligned LW, misaligned LH, illegal func3
        faulting(F3_W, 32'h101, 5'd10);
        faulting(F3_H, 32'h103, 5'd11);
        faulting(3'b011, 32'h100, 5'd12);

        // pass-through, including rd=0 suppression
        pass_through(5'd3, 1'b1, 32'h00001234, 1'b1);
        pass_through(5'd0, 1'b1, 32'h00005678, 1'b0);
        pass_through(5'd4, 1'b0, 32'h9ABCDEF0, 1'b0);

        // reset while a load is waiting for rvalid
        pass_through(5'd13, 1'b1, 32'h0000BEEF, 1'b1);
        drive(OPCODE_LOAD, F3_W, 32'h200, 32'h0, 5'd14, 1'b1);
        dmem.ready = 1'b1;
        #1;
        chk("mid_req", {31'd0, dmem.req}, 32'd1);
        tick();
        dmem.ready = 1'b0;
        #1;
        chk("mid_wait_stall", {31'd0, mem_stall}, 32'd1);
        rst_n = 1'b0;
        ex_valid = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, dmem.req}, 32'd0);
        chk("mid_rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("mid_rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("mid_rst_wb_data", wb_data, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        dmem.rvalid = 1'b1;
        dmem.rdata  = 32'hFFFFFFFF;
        tick();
        nop();
        #1;
        chk("late_rvalid_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("late_rvalid_stall", {31'd0, mem_stall}, 32'd0);
        tick(); tick();

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
